// File: rtl/div_seq.sv
// div_seq -- multi-cycle restoring divider for MIPS DIV / DIVU.
//
// Produces one quotient bit per clock. Signed operands are divided as
// magnitudes, and the signs are applied in a final FIX cycle.
// Quotient maps to LO and remainder maps to HI.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   start        request; sampled only while idle
//   signed_op    1 = DIV (two's complement), 0 = DIVU; sampled with start
//   dividend     numerator; sampled with start
//   divisor      denominator; sampled with start
//   busy         high while an operation is in progress
//   done         one-cycle pulse; results valid
//   quotient     registered quotient (LO)
//   remainder    registered remainder (HI)
//   div_by_zero  registered; set when the last op had divisor == 0
//
// Optional feature macro: DIV_ZERO_FAST_EN
//   When defined, a zero divisor is detected at the start edge and the CALC
//   phase is skipped, so done follows start after 2 cycles instead of
//   WIDTH+2. Result values are the same in both builds.

module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Holds the dividend magnitude. It shifts left every step and collects
    // quotient bits in its LSB.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   rem_sh, rem_sub;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        dvd_neg = signed_op & dividend[WIDTH-1];
        dvs_neg = signed_op & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor : divisor;

        rem_sh  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, dvs_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    q_neg_d = dvd_neg ^ dvs_neg;
                    r_neg_d = dvd_neg;
                    dz_d    = (divisor == '0);
                    cnt_d   = '0;
                    rem_d   = '0;
                    state_d = S_CALC;
`ifdef DIV_ZERO_FAST_EN
                    // Preload the partial remainder with the magnitude, which
                    // is what a full run against a zero divisor leaves behind.
                    // FIX then sign-restores the raw dividend the same way.
                    if (divisor == '0) begin
                        rem_d   = {1'b0, dvd_mag};
                        state_d = S_FIX;
                    end
`endif
                end
            end

            S_CALC: begin
                if (rem_sh >= {1'b0, dvs_q}) begin
                    rem_d = rem_sub;
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_FIX: begin
                quo_d   = dz_q ? '1 : (q_neg_q ? -dvd_q : dvd_q);
                // With a zero divisor, rem_q holds the dividend magnitude.
                // Applying r_neg therefore returns the raw dividend.
                remo_d  = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                dbz_d   = dz_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq -- directed testbench for div_seq (WIDTH = 32).
// Exercises reset, DIVU/DIV results, signed overflow, divide-by-zero,
// start while busy, asynchronous reset mid-operation, and back-to-back ops.
// Honours DIV_ZERO_FAST_EN for the expected divide-by-zero latency.

module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = 34;
`endif

    always #5 clk = ~clk;

    div_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Called at a negedge. Presents one request, scrambles the operand inputs
    // after the capture edge, and returns at the negedge of the done cycle.
    // lat is the cycle index where done appeared, or 0 on timeout.
    // busy_ok reports whether busy was 1 before done and 0 in the done cycle.
    task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy_ok);
        start     = 1'b1;
        signed_op = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        signed_op = ~sgn;
        dividend  = $urandom;
        divisor   = $urandom;
        lat       = 0;
        busy_ok   = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            if (done === 1'b1) begin
                lat = k;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (quotient !== 32'h0) begin n_bad++; $display("FAIL reset_q: got %h want 0", quotient); end
        n_cmp++; if (remainder !== 32'h0) begin n_bad++; $display("FAIL reset_r: got %h want 0", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    endtask

    task automatic test_divu_basic();
        int   lat;
        logic bok;
        do_op(1'b0, 32'd100, 32'd7, lat, bok);
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL divu_latency: got %0d want 34", lat); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL divu_busy: got %b want 1", bok); end
        n_cmp++; if (quotient !== 32'd14) begin n_bad++; $display("FAIL divu_q: got %h want %h", quotient, 32'd14); end
        n_cmp++; if (remainder !== 32'd2) begin n_bad++; $display("FAIL divu_r: got %h want %h", remainder, 32'd2); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL divu_dbz: got %b want 0", div_by_zero); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %b want 0", done); end
        n_cmp++; if (quotient !== 32'd14) begin n_bad++; $display("FAIL q_hold: got %h want %h", quotient, 32'd14); end
    endtask

    task automatic test_signed();
        int   lat;
        logic bok;
        do_op(1'b1, 32'hFFFF_FFF9, 32'h2, lat, bok);
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL sgn1_latency: got %0d want 34", lat); end
        n_cmp++; if (quotient !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL sgn1_q: got %h want FFFFFFFD", quotient); end
        n_cmp++; if (remainder !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sgn1_r: got %h want FFFFFFFF", remainder); end
        do_op(1'b1, 32'h7, 32'hFFFF_FFFE, lat, bok);
        n_cmp++; if (quotient !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL sgn2_q: got %h want FFFFFFFD", quotient); end
        n_cmp++; if (remainder !== 32'h1) begin n_bad++; $display("FAIL sgn2_r: got %h want 1", remainder); end
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
        n_cmp++; if (quotient !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_q: got %h want 80000000", quotient); end
        n_cmp++; if (remainder !== 32'h0) begin n_bad++; $display("FAIL ovf_r: got %h want 0", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL ovf_dbz: got %b want 0", div_by_zero); end
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok);
        n_cmp++; if (quotient !== 32'h1) begin n_bad++; $display("FAIL divu_max_q: got %h want 1", quotient); end
        n_cmp++; if (remainder !== 32'h0) begin n_bad++; $display("FAIL divu_max_r: got %h want 0", remainder); end
    endtask

    task automatic test_div_zero();
        int   lat;
        logic bok;
        do_op(1'b0, 32'h1234, 32'h0, lat, bok);
        n_cmp++; if (lat !== DZ_LAT) begin n_bad++; $display("FAIL dzu_latency: got %0d want %0d", lat, DZ_LAT); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL dzu_busy: got %b want 1", bok); end
        n_cmp++; if (quotient !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dzu_q: got %h want FFFFFFFF", quotient); end
        n_cmp++; if (remainder !== 32'h1234) begin n_bad++; $display("FAIL dzu_r: got %h want 1234", remainder); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dzu_dbz: got %b want 1", div_by_zero); end
        do_op(1'b1, 32'h1234, 32'h0, lat, bok);
        n_cmp++; if (lat !== DZ_LAT) begin n_bad++; $display("FAIL dzs_latency: got %0d want %0d", lat, DZ_LAT); end
        n_cmp++; if (quotient !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dzs_q: got %h want FFFFFFFF", quotient); end
        n_cmp++; if (remainder !== 32'h1234) begin n_bad++; $display("FAIL dzs_r: got %h want 1234", remainder); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dzs_dbz: got %b want 1", div_by_zero); end
        do_op(1'b1, 32'hFFFF_FFF0, 32'h0, lat, bok);
        n_cmp++; if (quotient !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dzneg_q: got %h want FFFFFFFF", quotient); end
        n_cmp++; if (remainder !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL dzneg_r: got %h want FFFFFFF0", remainder); end
        do_op(1'b0, 32'd9, 32'd3, lat, bok);
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL clr_latency: got %0d want 34", lat); end
        n_cmp++; if (quotient !== 32'd3) begin n_bad++; $display("FAIL clr_q: got %h want 3", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_bad++; $display("FAIL clr_r: got %h want 0", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL clr_dbz: got %b want 0", div_by_zero); end
    endtask

    task automatic test_ignore_start();
        int          first_done = 0;
        int          n_done = 0;
        logic [31:0] q_at_done = '0;
        logic [31:0] r_at_done = '0;
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            if (done === 1'b1) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = k;
                    q_at_done  = quotient;
                    r_at_done  = remainder;
                end
            end
            if (k == 10) begin
                start     = 1'b1;
                signed_op = 1'b0;
                dividend  = 32'd50;
                divisor   = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (first_done !== 34) begin n_bad++; $display("FAIL ign_latency: got %0d want 34", first_done); end
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL ign_done_count: got %0d want 1", n_done); end
        n_cmp++; if (q_at_done !== 32'd100) begin n_bad++; $display("FAIL ign_q: got %h want %h", q_at_done, 32'd100); end
        n_cmp++; if (r_at_done !== 32'd0) begin n_bad++; $display("FAIL ign_r: got %h want 0", r_at_done); end
        n_cmp++; if (quotient !== 32'd100) begin n_bad++; $display("FAIL ign_q_hold: got %h want %h", quotient, 32'd100); end
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic bok;
        do_op(1'b0, 32'h55, 32'h0, lat, bok);
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'h0001_2345;
        divisor   = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b want 0", done); end
        n_cmp++; if (quotient !== 32'h0) begin n_bad++; $display("FAIL rmid_q: got %h want 0", quotient); end
        n_cmp++; if (remainder !== 32'h0) begin n_bad++; $display("FAIL rmid_r: got %h want 0", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL rmid_dbz: got %b want 0", div_by_zero); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_op(1'b0, 32'd9, 32'd4, lat, bok);
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL post_rst_latency: got %0d want 34", lat); end
        n_cmp++; if (quotient !== 32'd2) begin n_bad++; $display("FAIL post_rst_q: got %h want 2", quotient); end
        n_cmp++; if (remainder !== 32'd1) begin n_bad++; $display("FAIL post_rst_r: got %h want 1", remainder); end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic bok;
        do_op(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, lat, bok);
        n_cmp++; if (quotient !== 32'd2) begin n_bad++; $display("FAIL b2b1_q: got %h want 2", quotient); end
        n_cmp++; if (remainder !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL b2b1_r: got %h want FFFFFFFE", remainder); end
        // Issued in the done cycle of the previous op.
        do_op(1'b0, 32'd1000, 32'd7, lat, bok);
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL b2b2_latency: got %0d want 34", lat); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL b2b2_busy: got %b want 1", bok); end
        n_cmp++; if (quotient !== 32'd142) begin n_bad++; $display("FAIL b2b2_q: got %h want %h", quotient, 32'd142); end
        n_cmp++; if (remainder !== 32'd6) begin n_bad++; $display("FAIL b2b2_r: got %h want 6", remainder); end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_divu_basic();
        test_signed();
        test_div_zero();
        @(negedge clk);
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
